vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 191 +++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA sync/timing generator with pixel-request look-ahead.
// Counts pixels and lines, issues pix_req ahead of consumption, and registers
// sync, data enable, line/frame pulses and colour.
// Optional feature: define VGA_TIMING_TPG_EN to build the colour-bar test
// pattern, which tpg_sel then selects. Without it, tpg_sel is ignored.

module vga_timing_gen #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1,
  parameter int unsigned REQ_LEAD = 1,
  parameter int unsigned DW       = 8
) (
  input  logic            vga_clk,
  input  logic            sys_rst_n,
  input  logic            en,
  input  logic            tpg_sel,
  input  logic [3*DW-1:0] pix_data,
  output logic            pix_req,
  output logic [11:0]     pix_x,
  output logic [11:0]     pix_y,
  output logic            hsync,
  output logic            vsync,
  output logic            de,
  output logic            line_start,
  output logic            frame_start,
  output logic [DW-1:0]   vga_r,
  output logic [DW-1:0]   vga_g,
  output logic [DW-1:0]   vga_b
);

  // 13-bit constants so that H_TOTAL/V_TOTAL of exactly 4096 and the look-ahead
  // sum h+REQ_LEAD never overflow. REQ_LEAD must stay within 1..H_BP.
  localparam logic [12:0] H_TOTAL  = 13'(H_SYNC + H_BP + H_ACTIVE + H_FP);
  localparam logic [12:0] V_TOTAL  = 13'(V_SYNC + V_BP + V_ACTIVE + V_FP);
  localparam logic [12:0] H_START  = 13'(H_SYNC + H_BP);
  localparam logic [12:0] H_END    = 13'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [12:0] V_START  = 13'(V_SYNC + V_BP);
  localparam logic [12:0] V_END    = 13'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [12:0] H_SYNC_W = 13'(H_SYNC);
  localparam logic [12:0] V_SYNC_W = 13'(V_SYNC);
  localparam logic [12:0] LEAD     = 13'(REQ_LEAD);
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 13'd1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 13'd1);

  logic [11:0]     h_q, h_d;
  logic [11:0]     v_q, v_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            de_q, de_d;
  logic            line_start_q, line_start_d;
  logic            frame_start_q, frame_start_d;
  logic [3*DW-1:0] rgb_q, rgb_d;

  logic [12:0]     h_ext;
  logic [12:0]     v_ext;
  logic [12:0]     h_lead;
  logic            h_active;
  logic            v_active;
  logic            h_req;
  logic            in_active;
  logic [3*DW-1:0] src_rgb;

  // Decode where the counters sit relative to the visible window, both for the
  // current position and for the position REQ_LEAD clocks ahead.
  always_comb begin
    h_ext     = {1'b0, h_q};
    v_ext     = {1'b0, v_q};
    h_lead    = h_ext + LEAD;
    h_active  = (h_ext >= H_START) && (h_ext < H_END);
    v_active  = (v_ext >= V_START) && (v_ext < V_END);
    h_req     = (h_lead >= H_START) && (h_lead < H_END);
    in_active = en && h_active && v_active;
  end

  // Pixel request and its coordinate are combinational so the source sees them early.
  always_comb begin
    pix_req = en && h_req && v_active;
    pix_x   = 12'hFFF;
    pix_y   = 12'hFFF;
    if (pix_req) begin
      pix_x = 12'(h_lead - H_START);
      pix_y = 12'(v_ext - V_START);
    end
  end

  // Next counter position: free-run while enabled, snap back to (0,0) when not.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!en) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
    end else begin
      h_d = h_q + 12'd1;
    end
  end

`ifdef VGA_TIMING_TPG_EN
  localparam int unsigned BAR_W_RAW = H_ACTIVE / 8;
  localparam logic [11:0] BAR_W     = 12'((BAR_W_RAW == 0) ? 1 : BAR_W_RAW);

  logic [11:0]     act_x;
  logic [11:0]     bar_idx;
  logic [2:0]      bar_rgb;
  logic [3*DW-1:0] tpg_rgb;

  // Colour bars keyed on the x being consumed this cycle; each channel is all-ones or zero.
  always_comb begin
    act_x   = 12'(h_ext - H_START);
    bar_idx = act_x / BAR_W;
    case (bar_idx)
      12'd0:   bar_rgb = 3'b111;
      12'd1:   bar_rgb = 3'b110;
      12'd2:   bar_rgb = 3'b011;
      12'd3:   bar_rgb = 3'b010;
      12'd4:   bar_rgb = 3'b101;
      12'd5:   bar_rgb = 3'b100;
      12'd6:   bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
    tpg_rgb = {{DW{bar_rgb[2]}}, {DW{bar_rgb[1]}}, {DW{bar_rgb[0]}}};
    src_rgb = tpg_sel ? tpg_rgb : pix_data;
  end
`else
  logic unused_tpg_sel;
  assign unused_tpg_sel = tpg_sel;
  assign src_rgb        = pix_data;
`endif

  // Output values for the next edge; everything sits at its idle level while disabled.
  always_comb begin
    hsync_d       = ~HS_POL;
    vsync_d       = ~VS_POL;
    de_d          = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    rgb_d         = '0;
    if (en) begin
      hsync_d       = (h_ext < H_SYNC_W) ? HS_POL : ~HS_POL;
      vsync_d       = (v_ext < V_SYNC_W) ? VS_POL : ~VS_POL;
      de_d          = in_active;
      rgb_d         = in_active ? src_rgb : '0;
      line_start_d  = (h_q == 12'd0);
      frame_start_d = (h_q == 12'd0) && (v_q == 12'd0);
    end
  end

  // State and output registers, cleared to the idle picture by reset.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      rgb_q         <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      rgb_q         <= rgb_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign vga_r       = rgb_q[3*DW-1:2*DW];
  assign vga_g       = rgb_q[2*DW-1:DW];
  assign vga_b       = rgb_q[DW-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: bench for vga_timing_gen.
// dut_a uses the default 640x480 timing for directed line/pixel checks;
// dut_b uses a tiny timing (HS_POL=VS_POL=0, REQ_LEAD=3) checked every cycle
// against a frame-position model under random enable activity.

module tb_vga_timing_gen;

  localparam int B_HSYNC = 6;
  localparam int B_HBP   = 5;
  localparam int B_HACT  = 16;
  localparam int B_HFP   = 3;
  localparam int B_VSYNC = 2;
  localparam int B_VBP   = 2;
  localparam int B_VACT  = 5;
  localparam int B_VFP   = 1;
  localparam int B_LEAD  = 3;
  localparam int B_DW    = 4;
  localparam int B_HT    = B_HSYNC + B_HBP + B_HACT + B_HFP;
  localparam int B_VT    = B_VSYNC + B_VBP + B_VACT + B_VFP;
  localparam int B_HS    = B_HSYNC + B_HBP;
  localparam int B_VS    = B_VSYNC + B_VBP;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic tpg_sel_a;
  logic tpg_sel_b;
  logic [23:0] pix_data_a;
  logic [11:0] pix_data_b;

  logic        pix_req_a, hsync_a, vsync_a, de_a, line_start_a, frame_start_a;
  logic [11:0] pix_x_a, pix_y_a;
  logic [7:0]  r_a, g_a, b_a;
  logic        pix_req_b, hsync_b, vsync_b, de_b, line_start_b, frame_start_b;
  logic [11:0] pix_x_b, pix_y_b;
  logic [3:0]  r_b, g_b, b_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .vga_clk(clk), .sys_rst_n(rst_n), .en(en), .tpg_sel(tpg_sel_a),
    .pix_data(pix_data_a), .pix_req(pix_req_a), .pix_x(pix_x_a), .pix_y(pix_y_a),
    .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .line_start(line_start_a),
    .frame_start(frame_start_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a)
  );

  vga_timing_gen #(
    .H_SYNC(B_HSYNC), .H_BP(B_HBP), .H_ACTIVE(B_HACT), .H_FP(B_HFP),
    .V_SYNC(B_VSYNC), .V_BP(B_VBP), .V_ACTIVE(B_VACT), .V_FP(B_VFP),
    .HS_POL(1'b0), .VS_POL(1'b0), .REQ_LEAD(B_LEAD), .DW(B_DW)
  ) dut_b (
    .vga_clk(clk), .sys_rst_n(rst_n), .en(en), .tpg_sel(tpg_sel_b),
    .pix_data(pix_data_b), .pix_req(pix_req_b), .pix_x(pix_x_b), .pix_y(pix_y_b),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .line_start(line_start_b),
    .frame_start(frame_start_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
  );

  // Reference picture content for dut_b and the pixel source's delay line.
  logic [11:0] pixmem [B_VACT][B_HACT];
  logic [11:0] hist [B_LEAD+1];
  logic [11:0] prev_a;

  // Model state: cycles since the frame (re)started, plus expected registered outputs.
  int          pos;
  logic        e_hs, e_vs, e_de, e_ls, e_fs;
  logic [11:0] e_rgb;
  int          hcnt_a;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
    logic [11:0] px;
  } vec_t;

  vec_t vecs [11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] tpgExpected(input int x);
`ifdef VGA_TIMING_TPG_EN
    case (x / 80)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
`else
    return 24'(x);
`endif
  endfunction

  // What the rising edge does according to the timing rules for dut_b.
  task automatic modelEdge();
    int h, v;
    logic act;
    if (!rst_n || !en) begin
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_ls = 1'b0; e_fs = 1'b0; e_rgb = '0;
      pos = 0;
    end else begin
      h = pos % B_HT;
      v = pos / B_HT;
      act   = (h >= B_HS) && (h < B_HS + B_HACT) && (v >= B_VS) && (v < B_VS + B_VACT);
      e_hs  = !(h < B_HSYNC);
      e_vs  = !(v < B_VSYNC);
      e_de  = act;
      e_rgb = act ? pixmem[v - B_VS][h - B_HS] : 12'h000;
      e_ls  = (h == 0);
      e_fs  = (pos == 0);
      pos   = (pos + 1) % (B_HT * B_VT);
    end
  endtask

  // One clock: model the edge, compare dut_b at the falling edge, then feed both sources.
  task automatic tick();
    int h, v, lead;
    logic req;
    logic [11:0] val;
    modelEdge();
    @(negedge clk);
    h    = pos % B_HT;
    v    = pos / B_HT;
    lead = h + B_LEAD;
    req  = rst_n && en && (lead >= B_HS) && (lead < B_HS + B_HACT) &&
           (v >= B_VS) && (v < B_VS + B_VACT);
    checkOutput("b_hsync", hsync_b, e_hs);
    checkOutput("b_vsync", vsync_b, e_vs);
    checkOutput("b_de", de_b, e_de);
    checkOutput("b_line_start", line_start_b, e_ls);
    checkOutput("b_frame_start", frame_start_b, e_fs);
    checkOutput("b_rgb", {r_b, g_b, b_b}, e_rgb);
    checkOutput("b_pix_req", pix_req_b, req);
    checkOutput("b_pix_x", pix_x_b, req ? 32'(lead - B_HS) : 32'hFFF);
    checkOutput("b_pix_y", pix_y_b, req ? 32'(v - B_VS) : 32'hFFF);
    val = 12'h000;
    if (pix_req_b && pix_x_b < 12'(B_HACT) && pix_y_b < 12'(B_VACT))
      val = pixmem[pix_y_b][pix_x_b];
    for (int i = B_LEAD; i > 0; i--) hist[i] = hist[i-1];
    hist[0]    = val;
    pix_data_b = hist[B_LEAD];
    pix_data_a = {12'h000, prev_a};
    prev_a     = pix_req_a ? pix_x_a : 12'h000;
    if (line_start_a) hcnt_a = 1;
    else hcnt_a++;
  endtask

  task automatic applyStimulus(input vec_t vc, input int idx);
    rst_n = vc.rst_n;
    en    = vc.en;
    tick();
    checkOutput($sformatf("vec%0d_hsync", idx), hsync_a, vc.hs);
    checkOutput($sformatf("vec%0d_vsync", idx), vsync_a, vc.vs);
    checkOutput($sformatf("vec%0d_de", idx), de_a, vc.de);
    checkOutput($sformatf("vec%0d_line_start", idx), line_start_a, vc.ls);
    checkOutput($sformatf("vec%0d_frame_start", idx), frame_start_a, vc.fs);
    checkOutput($sformatf("vec%0d_pix_x", idx), pix_x_a, vc.px);
    checkOutput($sformatf("vec%0d_rgb", idx), {r_a, g_a, b_a}, 24'h0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, len, hs, k;
    rst_n = 1'b0; en = 1'b1; tpg_sel_a = 1'b0; tpg_sel_b = 1'b0;
    pix_data_a = '0; pix_data_b = '0; prev_a = '0; pos = 0; hcnt_a = 0;
    for (int i = 0; i <= B_LEAD; i++) hist[i] = '0;
    for (int y = 0; y < B_VACT; y++)
      for (int x = 0; x < B_HACT; x++) pixmem[y][x] = 12'($urandom);

    // Reset hold, release, enable drop and re-enable on the default-timing instance.
    for (int i = 0; i < 5; i++) vecs[i] = '{1'b0, 1'b1, 0, 0, 0, 0, 0, 12'hFFF};
    vecs[5]  = '{1'b1, 1'b1, 1, 1, 0, 1, 1, 12'hFFF};
    vecs[6]  = '{1'b1, 1'b1, 1, 1, 0, 0, 0, 12'hFFF};
    vecs[7]  = '{1'b1, 1'b0, 0, 0, 0, 0, 0, 12'hFFF};
    vecs[8]  = '{1'b1, 1'b0, 0, 0, 0, 0, 0, 12'hFFF};
    vecs[9]  = '{1'b1, 1'b1, 1, 1, 0, 1, 1, 12'hFFF};
    vecs[10] = '{1'b1, 1'b1, 1, 1, 0, 0, 0, 12'hFFF};
    for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);

    // Line length and hsync width on a vertical-sync line.
    n = 0;
    while (!line_start_a && n < 2000) begin tick(); n++; end
    checkOutput("a_line_start_seen", line_start_a, 1'b1);
    len = 0; hs = 0;
    do begin
      if (hsync_a) hs++;
      len++;
      tick();
    end while (!line_start_a && len < 1000);
    checkOutput("a_line_len", len, 800);
    checkOutput("a_hsync_width", hs, 96);

    // First pixel request of the frame: h=143, x=0, y=0.
    n = 0;
    while (!pix_req_a && n < 40000) begin tick(); n++; end
    checkOutput("a_req_seen", pix_req_a, 1'b1);
    checkOutput("a_req_h", hcnt_a, 143);
    checkOutput("a_req_x", pix_x_a, 12'd0);
    checkOutput("a_req_y", pix_y_a, 12'd0);

    // The first active line carries x as data, starting from 0, for 640 clocks.
    n = 0;
    while (!de_a && n < 10) begin tick(); n++; end
    checkOutput("a_de_seen", de_a, 1'b1);
    k = 0;
    while (de_a && k < 1000) begin
      if (k < 640) checkOutput("a_rgb_x", {r_a, g_a, b_a}, 24'(k));
      k++;
      tick();
    end
    checkOutput("a_de_width", k, 640);

    // Next line with the test pattern selected.
    tpg_sel_a = 1'b1;
    n = 0;
    while (!de_a && n < 1000) begin tick(); n++; end
    checkOutput("a_tpg_de_seen", de_a, 1'b1);
    k = 0;
    while (de_a && k < 1000) begin
      if (k == 0 || k == 80 || k == 320 || k == 639)
        checkOutput($sformatf("a_tpg_x%0d", k), {r_a, g_a, b_a}, tpgExpected(k));
      k++;
      tick();
    end
    tpg_sel_a = 1'b0;

    // Random enable activity against the model.
    for (int i = 0; i < 3000; i++) begin
      if (en) en = ($urandom_range(0, 399) != 0);
      else en = ($urandom_range(0, 2) == 0);
      tick();
    end

    // Abort mid-line at v=5, h=14 inside the active window, then restart.
    en = 1'b1;
    n = 0;
    while (pos != 5 * B_HT + 14 && n < 400) begin tick(); n++; end
    checkOutput("b_abort_pos_found", pos, 5 * B_HT + 14);
    en = 1'b0;
    tick();
    checkOutput("b_abort_de", de_b, 1'b0);
    checkOutput("b_abort_hsync", hsync_b, 1'b1);
    checkOutput("b_abort_req", pix_req_b, 1'b0);
    tick();
    en = 1'b1;
    tick();
    checkOutput("b_restart_fs", frame_start_b, 1'b1);
    n = 0;
    do begin tick(); n++; end while (!line_start_b && n < 100);
    checkOutput("b_restart_line_len", n, B_HT);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_a_hsync", hsync_a, 1'b0);
    checkOutput("async_b_hsync", hsync_b, 1'b1);
    checkOutput("async_b_vsync", vsync_b, 1'b1);
    checkOutput("async_b_de", de_b, 1'b0);
    checkOutput("async_b_pix_x", pix_x_b, 12'hFFF);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("rst_release_fs_a", frame_start_a, 1'b1);
    tick();
    checkOutput("rst_release_fs_b_next", frame_start_b, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
